// File: rtl/exibe_sequencia.sv
// exibe_sequencia: plays the stored move sequence 0..limite on the LEDs,
// each move lit for ON_CYCLES then blanked for OFF_CYCLES. Rev 1.0.
`default_nettype none

module exibe_sequencia #(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 4,
   parameter int ON_CYCLES  = 500,
   parameter int OFF_CYCLES = 250
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic [ADDR_W-1:0] limite,
   input  logic [DATA_W-1:0] dado,
   output logic [ADDR_W-1:0] endereco,
   output logic [DATA_W-1:0] leds,
   output logic              exibindo,
   output logic              pronto,
   output logic [3:0]        db_estado
);

   localparam int C_MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int C_TMR_W      = $clog2(C_MAX_CYCLES) + 1;

   localparam logic [C_TMR_W-1:0] C_ON_LAST  = C_TMR_W'(ON_CYCLES - 1);
   localparam logic [C_TMR_W-1:0] C_OFF_LAST = C_TMR_W'(OFF_CYCLES - 1);

   localparam logic [3:0] C_ST_INICIAL    = 4'd0;
   localparam logic [3:0] C_ST_PREPARACAO = 4'd1;
   localparam logic [3:0] C_ST_CARREGA    = 4'd2;
   localparam logic [3:0] C_ST_MOSTRA     = 4'd3;
   localparam logic [3:0] C_ST_APAGA      = 4'd4;
   localparam logic [3:0] C_ST_PROXIMO    = 4'd5;
   localparam logic [3:0] C_ST_FINAL      = 4'd6;

   logic [3:0]         estado_q,   estado_d;
   logic [ADDR_W-1:0]  endereco_q, endereco_d;
   logic [DATA_W-1:0]  leds_q,     leds_d;
   logic [C_TMR_W-1:0] timer_q,    timer_d;
   logic [ADDR_W-1:0]  limite_q,   limite_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q   <= C_ST_INICIAL;
         endereco_q <= '0;
         leds_q     <= '0;
         timer_q    <= '0;
         limite_q   <= '0;
      end else begin
         estado_q   <= estado_d;
         endereco_q <= endereco_d;
         leds_q     <= leds_d;
         timer_q    <= timer_d;
         limite_q   <= limite_d;
      end
   end

   always_comb begin
      estado_d   = estado_q;
      endereco_d = endereco_q;
      leds_d     = leds_q;
      timer_d    = timer_q;
      limite_d   = limite_q;
      case (estado_q)
         C_ST_INICIAL: begin
            if (iniciar) estado_d = C_ST_PREPARACAO;
         end
         C_ST_PREPARACAO: begin
            endereco_d = '0;
            timer_d    = '0;
            limite_d   = limite;
            leds_d     = '0;
            estado_d   = C_ST_CARREGA;
         end
         C_ST_CARREGA: begin
            leds_d   = dado;
            timer_d  = '0;
            estado_d = C_ST_MOSTRA;
         end
         C_ST_MOSTRA: begin
            if (timer_q == C_ON_LAST) begin
               timer_d  = '0;
               leds_d   = '0;
               estado_d = C_ST_APAGA;
            end else begin
               timer_d = timer_q + C_TMR_W'(1);
            end
         end
         C_ST_APAGA: begin
            leds_d = '0;
            // Terminal test happens before the increment, so endereco never wraps.
            if (timer_q == C_OFF_LAST) begin
               timer_d  = '0;
               estado_d = (endereco_q == limite_q) ? C_ST_FINAL : C_ST_PROXIMO;
            end else begin
               timer_d = timer_q + C_TMR_W'(1);
            end
         end
         C_ST_PROXIMO: begin
            endereco_d = endereco_q + ADDR_W'(1);
            estado_d   = C_ST_CARREGA;
         end
         C_ST_FINAL: begin
            leds_d = '0;
            if (iniciar) estado_d = C_ST_PREPARACAO;
         end
         default: begin
            estado_d = C_ST_INICIAL;
         end
      endcase
   end

   always_comb begin
      exibindo  = (estado_q == C_ST_CARREGA) || (estado_q == C_ST_MOSTRA) ||
                  (estado_q == C_ST_APAGA)   || (estado_q == C_ST_PROXIMO);
      pronto    = (estado_q == C_ST_FINAL);
      db_estado = estado_q;
   end

   assign endereco = endereco_q;
   assign leds     = leds_q;

endmodule

`default_nettype wire
